// File: rtl/count_stamp_pkg.sv
// Shared types for the count_stamp slice: FSM states, timestamp layout and
// the width helper used to size the timestamp from its two fields.
package count_stamp_pkg;

    localparam int unsigned CNT_W_DEF  = 4;
    localparam int unsigned WRAP_W_DEF = 8;

    typedef enum logic [1:0] {
        SYNC,
        LOCKED,
        FAULT
    } stamp_state_e;

    function automatic int unsigned ts_width(input int unsigned wrap_w, input int unsigned cnt_w);
        return wrap_w + cnt_w;
    endfunction

    localparam int unsigned TS_W_DEF = ts_width(WRAP_W_DEF, CNT_W_DEF);

    typedef struct packed {
        logic [WRAP_W_DEF-1:0] wrap;
        logic [CNT_W_DEF-1:0]  cnt;
    } ts_t;

endpackage

// File: rtl/stamp_fifo.sv
// Generic synchronous FIFO; a push into a full FIFO is accepted only when a
// pop happens on the same edge. Head reads as zero while empty.
module stamp_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [AW:0]      r_cnt;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_cnt == '0);
    assign o_full    = (r_cnt == (AW+1)'(DEPTH));
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_dout    = o_empty ? '0 : r_mem[r_rd];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_do_push) r_wr <= r_wr + 1'b1;
            if (w_do_pop)  r_rd <= r_rd + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr] <= i_din;
    end

endmodule

// File: rtl/count_stamp.sv
// Tracks an upstream 4-bit counter, extends it with a wrap count into a
// timestamp, flags illegal steps, and queues triggered timestamps.
module count_stamp
    import count_stamp_pkg::*;
#(
    parameter int unsigned CNT_W  = 4,
    parameter int unsigned WRAP_W = 8,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [CNT_W-1:0]                   q_in,
    input  logic                               trig,
    input  logic                               ovf_clr,
    output logic [ts_width(WRAP_W, CNT_W)-1:0] ts_data,
    output logic                               ts_valid,
    input  logic                               ts_ready,
    output logic                               locked,
    output logic                               step_err,
    output logic                               ovf
);

    localparam int unsigned TS_W = ts_width(WRAP_W, CNT_W);

    stamp_state_e      r_state;
    stamp_state_e      w_state_next;
    logic [CNT_W-1:0]  r_prev;
    logic [WRAP_W-1:0] r_wrap;
    logic [WRAP_W-1:0] w_wrap_next;
    logic [CNT_W-1:0]  w_exp;
    logic              w_hold_zero;
    logic              w_stay_locked;
    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic              r_ovf;

    assign w_exp       = r_prev + 1'b1;
    assign w_hold_zero = (q_in == '0) && (r_prev == '0);

    always_comb begin
        w_state_next  = r_state;
        w_wrap_next   = r_wrap;
        w_stay_locked = 1'b0;
        case (r_state)
            SYNC: begin
                if (q_in == CNT_W'(1) && r_prev == '0) begin
                    w_state_next = LOCKED;
                    w_wrap_next  = '0;
                end
            end
            LOCKED: begin
                if (w_hold_zero) begin
                    w_state_next = SYNC;
                    w_wrap_next  = '0;
                end else if (q_in == w_exp) begin
                    w_stay_locked = 1'b1;
                    if (r_prev == '1) w_wrap_next = r_wrap + 1'b1;
                end else begin
                    w_state_next = FAULT;
                end
            end
            FAULT: begin
                if (w_hold_zero) begin
                    w_state_next = SYNC;
                    w_wrap_next  = '0;
                end
            end
            default: begin
                w_state_next = SYNC;
                w_wrap_next  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= SYNC;
            r_prev  <= '0;
            r_wrap  <= '0;
        end else begin
            r_state <= w_state_next;
            r_prev  <= q_in;
            r_wrap  <= w_wrap_next;
        end
    end

    // Captured stamp uses the post-increment wrap so a trigger on the 15->0 sample is consistent.
    assign w_push = trig && w_stay_locked;
    assign w_pop  = ts_valid && ts_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_push && w_full && !w_pop) begin
            r_ovf <= 1'b1;
        end else if (ovf_clr) begin
            r_ovf <= 1'b0;
        end
    end

    stamp_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (TS_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   ({w_wrap_next, q_in}),
        .o_dout  (ts_data),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign ts_valid = !w_empty;
    assign locked   = (r_state == LOCKED);
    assign step_err = (r_state == FAULT);
    assign ovf      = r_ovf;

endmodule

// File: tb/tb_count_stamp.sv
// Directed bench for count_stamp: lock-in, wrap extension, step fault,
// FIFO overflow/drain, full push+pop and mid-operation reset.
module tb_count_stamp;
    import count_stamp_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  q_in;
    logic        trig;
    logic        ovf_clr;
    logic [11:0] ts_data;
    logic        ts_valid;
    logic        ts_ready;
    logic        locked;
    logic        step_err;
    logic        ovf;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    count_stamp #(
        .CNT_W  (4),
        .WRAP_W (8),
        .DEPTH  (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .q_in     (q_in),
        .trig     (trig),
        .ovf_clr  (ovf_clr),
        .ts_data  (ts_data),
        .ts_valid (ts_valid),
        .ts_ready (ts_ready),
        .locked   (locked),
        .step_err (step_err),
        .ovf      (ovf)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] stamp(input int w, input int c);
        ts_t t;
        t.wrap = w[7:0];
        t.cnt  = c[3:0];
        return t;
    endfunction

    // Drive q_in, let one edge pass, return 1 time unit after it.
    task automatic tick(input int q);
        q_in = q[3:0];
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; q_in = '0; trig = 1'b0; ovf_clr = 1'b0; ts_ready = 1'b0;
        tick(0);
        tick(0);
        rst = 1'b0;
        check("rst_valid", ts_valid, 0);
        check("rst_data", ts_data, 0);
        check("rst_locked", locked, 0);
        check("rst_err", step_err, 0);
        check("rst_ovf", ovf, 0);

        // lock-in
        tick(0); tick(0); tick(0);
        check("sync_locked", locked, 0);
        tick(1);
        check("lock_locked", locked, 1);
        tick(2); tick(3);
        check("lock_hold", locked, 1);
        check("lock_err", step_err, 0);

        // wrap extension: two 15->0 wraps then trigger at 5
        for (int q = 4; q < 16; q++) tick(q);
        for (int q = 0; q < 16; q++) tick(q);
        for (int q = 0; q < 5; q++) tick(q);
        check("pre_trig_valid", ts_valid, 0);
        trig = 1'b1;
        tick(5);
        trig = 1'b0;
        check("wrap_valid", ts_valid, 1);
        check("wrap_data", ts_data, stamp(2, 5));
        ts_ready = 1'b1;
        tick(6);
        ts_ready = 1'b0;
        check("wrap_popped", ts_valid, 0);

        // step fault
        tick(9);
        check("fault_err", step_err, 1);
        check("fault_locked", locked, 0);
        trig = 1'b1;
        tick(10);
        trig = 1'b0;
        check("fault_trig", ts_valid, 0);
        check("fault_sticky", step_err, 1);
        tick(0);
        check("fault_one_zero", step_err, 1);
        tick(0);
        check("resync_err", step_err, 0);
        check("resync_locked", locked, 0);
        tick(1);
        check("relock", locked, 1);
        tick(2);

        // FIFO full / overflow
        trig = 1'b1;
        for (int q = 3; q < 7; q++) tick(q);
        check("full_no_ovf", ovf, 0);
        tick(7);
        trig = 1'b0;
        check("ovf_set", ovf, 1);
        ts_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("drain%0d", k), ts_data, stamp(0, 3 + k));
            tick(8 + k);
        end
        ts_ready = 1'b0;
        check("drain_empty", ts_valid, 0);
        check("ovf_sticky", ovf, 1);
        ovf_clr = 1'b1;
        tick(12);
        ovf_clr = 1'b0;
        check("ovf_clr", ovf, 0);

        // simultaneous push/pop when full; 15->0 sample pushes wrap=1
        trig = 1'b1;
        tick(13); tick(14); tick(15); tick(0);
        check("fill_head", ts_data, stamp(0, 13));
        ts_ready = 1'b1;
        tick(1);
        ts_ready = 1'b0;
        check("pp_no_ovf", ovf, 0);
        check("pp_head", ts_data, stamp(0, 14));
        tick(2);
        check("pp_still_full", ovf, 1);
        ovf_clr = 1'b1;
        tick(3);
        check("ovf_set_wins", ovf, 1);
        trig = 1'b0;
        tick(4);
        ovf_clr = 1'b0;
        check("ovf_clr2", ovf, 0);
        ts_ready = 1'b1;
        check("pp_d0", ts_data, stamp(0, 14)); tick(5);
        check("pp_d1", ts_data, stamp(0, 15)); tick(6);
        check("pp_d2", ts_data, stamp(1, 0));  tick(7);
        check("pp_d3", ts_data, stamp(1, 1));  tick(8);
        ts_ready = 1'b0;
        check("pp_empty", ts_valid, 0);

        // reset mid-operation
        trig = 1'b1;
        tick(9); tick(10); tick(11);
        trig = 1'b0;
        check("mid_valid", ts_valid, 1);
        check("mid_data", ts_data, stamp(1, 9));
        check("mid_locked", locked, 1);
        rst = 1'b1;
        tick(12);
        rst = 1'b0;
        check("mrst_valid", ts_valid, 0);
        check("mrst_data", ts_data, 0);
        check("mrst_locked", locked, 0);
        check("mrst_ovf", ovf, 0);
        tick(0);
        tick(1);
        check("mrst_relock", locked, 1);
        trig = 1'b1;
        tick(2);
        trig = 1'b0;
        check("mrst_wrap0", ts_data, stamp(0, 2));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/count_stamp.md
Name: count_stamp

Overview:
- Sits directly downstream of the free-running 4-bit `counter` and consumes its `q` output.
- Extends that count into a wider timestamp by counting 15->0 wraps.
- Checks that the upstream count steps legally.
- On a trigger pulse, captures the timestamp into a small FIFO drained through a valid/ready handshake.

Parameters:
- CNT_W, 4, width of the upstream count (matches `counter` `q`).
- WRAP_W, 8, width of the wrap counter; timestamp width TS_W = WRAP_W + CNT_W.
- DEPTH, 4, FIFO entries; must be a power of 2, at least 2.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- q_in  in  CNT_W  count from upstream `counter`.
- trig  in  1  capture request, one sample per cycle.
- ovf_clr  in  1  clears the sticky `ovf` flag.
- ts_data  out  TS_W  FIFO head timestamp {wrap, count}.
- ts_valid  out  1  FIFO not empty.
- ts_ready  in  1  consumer accepts the head.
- locked  out  1  FSM is in LOCKED.
- step_err  out  1  FSM is in FAULT.
- ovf  out  1  sticky flag: a capture was dropped because the FIFO was full.

Behaviour:
- Reset (rst=1 at a clk edge) sets: FSM=SYNC, prev=0, wrap=0, FIFO empty, ts_valid=0, ts_data=0, locked=0, step_err=0, ovf=0. Reset applied mid-operation discards FIFO contents.
- prev is the q_in value registered at the previous edge. exp = prev+1 mod 2^CNT_W.
- A "hold-zero" cycle is q_in==0 && prev==0; this indicates upstream is in reset.
- FSM, evaluated every edge (rst has priority):
  - SYNC: go to LOCKED when q_in==1 && prev==0, with wrap=0. Otherwise stay.
  - LOCKED:
    - hold-zero: go to SYNC, wrap=0.
    - q_in==exp: stay. If prev==2^CNT_W-1 (wrap), wrap increments mod 2^WRAP_W; wrap-around of wrap itself is silent.
    - any other value: go to FAULT.
  - FAULT: hold-zero goes to SYNC and clears wrap. Otherwise stay; FAULT is sticky until upstream reset or rst.
- Outputs: locked = (state==LOCKED); step_err = (state==FAULT). Both are registered, i.e. state bits.
- Capture:
  - At an edge with trig=1 and state==LOCKED and the transition stays in LOCKED, push {wrap_next, q_in}.
  - wrap_next includes the increment caused by this same sample.
  - trig in SYNC/FAULT, or on the edge that leaves LOCKED, is ignored: no push, no ovf.
- FIFO:
  - Pop when ts_valid && ts_ready at an edge.
  - A push while full with a simultaneous pop is accepted; occupancy stays DEPTH.
  - A push while full without a pop is dropped and sets ovf=1.
  - ovf_clr=1 clears ovf. If a drop and ovf_clr coincide, ovf=1 (set wins).
  - ts_data shows the head entry; it is stable while ts_valid && !ts_ready.
  - ts_data is don't-care when empty, driven 0 after reset.
  - Latency: a push at edge k gives ts_valid=1 after edge k (1 cycle trig-to-valid).
  - Push into an empty FIFO with ts_ready=1 is not popped on the same edge.
- Widths: all arithmetic is unsigned, wrapping modulo its field width; there is no saturation.

Decomposition:
- Package `count_stamp_pkg` holds:
  - enum `stamp_state_e` {SYNC, LOCKED, FAULT}.
  - localparam TS_W derivation helper.
  - typedef `ts_t` (packed struct {wrap, cnt}).
- One sub-module: `stamp_fifo`, a generic synchronous FIFO (DEPTH, width TS_W) with push, pop, full, empty, head.
- Sequence tracking, the FSM, and the ovf logic stay in count_stamp.

Test Plan:
- Lock-in: hold q_in=0 three cycles, then drive 1,2,3 -> locked=1 after the edge sampling q_in=1. wrap=0, step_err=0.
- Wrap extension: drive a locked ramp through 15->0 twice, then trig when q_in=5 -> ts_valid next cycle, ts_data=0x025 (wrap=2, cnt=5).
- Step fault: locked, drive q_in 6 then 9 -> step_err=1 and locked=0 after the 9 edge. trig has no effect. q_in 0,0 then 1 -> SYNC, then LOCKED with wrap=0.
- FIFO full/overflow:
  - With ts_ready=0, trig 5 consecutive cycles at q_in=3..7 (wrap=0) -> 4 entries 0x003..0x006; ovf=1 after the 5th.
  - ts_ready=1 then drains in order 0x003,0x004,0x005,0x006.
  - ovf_clr -> ovf=0.
- Simultaneous push/pop when full: FIFO full, trig=1 and ts_ready=1 on the same edge -> no ovf; occupancy stays 4; new entry appears last.
- Reset mid-operation: 3 entries queued and LOCKED, assert rst one edge -> ts_valid=0, locked=0, ovf=0, wrap=0. Upstream ramp restart 0,1 relocks.
